pipeline_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Drives the per-stage register

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/pipeline_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_t      : multiply occupancy FSM encoding (RUN / MUL_BUSY)
//   MUL_LAT_DEF  : default EX occupancy of a multiply-class instruction
//   CNT_W_DEF    : default performance counter width
//   MCNT_W       : multiply down-counter width (covers MUL_LAT up to 16)
package pipeline_ctrl_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

   localparam int MUL_LAT_DEF = 4;
   localparam int CNT_W_DEF   = 32;
   localparam int MCNT_W      = 4;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently in EX. r0 is never a hazard.
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   idex_mem_read, idex_reg_write, idex_dest_reg : EX-stage load info
//   hazard : single hazard bit
module pipeline_ctrl_load_use_detect (
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       idex_mem_read,
   input  logic       idex_reg_write,
   input  logic [4:0] idex_dest_reg,
   output logic       hazard
);

   logic src_match;

   assign src_match = (id_uses_rs1 && (id_rs1 == idex_dest_reg)) ||
                      (id_uses_rs2 && (id_rs2 == idex_dest_reg));

   assign hazard = idex_mem_read && idex_reg_write &&
                   (idex_dest_reg != 5'd0) && src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Same-cycle decision: all enables/strobes are combinational from state+inputs.
//   clk, rst (async, active low)
//   id_*            : ID-stage operand usage for load-use detection
//   idex_*          : EX-stage load/writeback info
//   ex_mul_start    : multiply-class instruction held in EX (level)
//   ex_branch_taken : taken branch/jump resolved in EX
//   halt_req        : debug halt (level)
//   *_we            : stage register load enables
//   *_flush         : bubble/NOP strobes
//   mul_busy        : FSM in MUL_BUSY
//   stall_cnt       : saturating count of non-halt cycles with pc_we=0
//   flush_cnt       : saturating count of taken-branch flushes
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             idex_MemRead,
   input  logic             idex_RegWrite,
   input  logic [4:0]       idex_DestReg,
   input  logic             ex_mul_start,
   input  logic             ex_branch_taken,
   input  logic             halt_req,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mul_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_t             state, state_nxt;
   logic  [MCNT_W-1:0] mul_cnt, mul_cnt_nxt;
   logic               lu_hazard;
   logic               stall_inc, flush_inc;

   pipeline_ctrl_load_use_detect u_lu (
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .idex_mem_read  (idex_MemRead),
      .idex_reg_write (idex_RegWrite),
      .idex_dest_reg  (idex_DestReg),
      .hazard         (lu_hazard)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         mul_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mul_cnt <= mul_cnt_nxt;
         if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt   = state;
      mul_cnt_nxt = mul_cnt;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      mul_busy    = (state == ST_MUL_BUSY);

      if (!rst) begin
         // Reset is asynchronous, so outputs must quiesce immediately too.
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         memwb_we = 1'b0;
         mul_busy = 1'b0;
      end else if (state == ST_RUN) begin
         if (halt_req) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
         end else if (ex_branch_taken) begin
            // Younger instructions are on the wrong path; mul/load-use ignored.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
         end else if (ex_mul_start) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            stall_inc   = 1'b1;
            mul_cnt_nxt = MCNT_W'(MUL_LAT - 2);
            state_nxt   = ST_MUL_BUSY;
         end else if (lu_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
         end
      end else begin
         // MUL_BUSY: halt and load-use wait for the release cycle.
         if (mul_cnt != '0) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            stall_inc   = 1'b1;
            mul_cnt_nxt = mul_cnt - MCNT_W'(1);
         end else begin
            state_nxt = ST_RUN;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MUL_LAT=4, CNT_W=32).
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, idex_DestReg;
   logic        id_uses_rs1, id_uses_rs2, idex_MemRead, idex_RegWrite;
   logic        ex_mul_start, ex_branch_taken, halt_req;
   logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic        ifid_flush, idex_flush, exmem_flush, mul_busy;
   logic [31:0] stall_cnt, flush_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .idex_MemRead(idex_MemRead), .idex_RegWrite(idex_RegWrite),
      .idex_DestReg(idex_DestReg),
      .ex_mul_start(ex_mul_start), .ex_branch_taken(ex_branch_taken),
      .halt_req(halt_req),
      .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
      .exmem_we(exmem_we), .memwb_we(memwb_we),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .mul_busy(mul_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   logic [4:0] we_v;
   logic [2:0] fl_v;
   assign we_v = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
   assign fl_v = {ifid_flush, idex_flush, exmem_flush};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // outputs: enables {pc,ifid,idex,exmem,memwb}, flushes {ifid,idex,exmem}, busy
   task automatic chk_out(input string tag, input logic [4:0] we, input logic [2:0] fl,
                          input logic busy);
      chk({tag, ".we"}, 64'(we_v), 64'(we));
      chk({tag, ".flush"}, 64'(fl_v), 64'(fl));
      chk({tag, ".busy"}, 64'(mul_busy), 64'(busy));
   endtask

   task automatic clr_in();
      id_rs1 = 0; id_rs2 = 0; idex_DestReg = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; idex_MemRead = 0; idex_RegWrite = 0;
      ex_mul_start = 0; ex_branch_taken = 0; halt_req = 0;
   endtask

   // Advance one clock; inputs are then driven 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu(input logic [4:0] dest);
      idex_MemRead = 1; idex_RegWrite = 1; idex_DestReg = dest;
   endtask

   initial begin
      clr_in();
      rst_n = 1'b0;
      #1;
      chk_out("rst0", 5'b00000, 3'b000, 1'b0);
      chk("rst0.stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst0.flush_cnt", 64'(flush_cnt), 64'd0);
      #11 rst_n = 1'b1;
      step();

      // idle RUN
      #1 chk_out("idle", 5'b11111, 3'b000, 1'b0);

      // load-use on rs2
      set_lu(5'd5); id_rs2 = 5'd5; id_uses_rs2 = 1;
      #1 chk_out("lu_rs2", 5'b00111, 3'b010, 1'b0);
      step();
      clr_in();
      #1 chk_out("lu_after", 5'b11111, 3'b000, 1'b0);
      chk("lu.stall_cnt", 64'(stall_cnt), 64'd1);

      // matching rs1 that the instruction does not read: no hazard
      set_lu(5'd7); id_rs1 = 5'd7; id_uses_rs1 = 0;
      #1 chk_out("lu_unused", 5'b11111, 3'b000, 1'b0);
      // load into r0: never a hazard
      set_lu(5'd0); id_rs1 = 5'd0; id_uses_rs1 = 1;
      #1 chk_out("lu_r0", 5'b11111, 3'b000, 1'b0);
      // non-load writing the source register: no hazard
      idex_MemRead = 0; idex_DestReg = 5'd9; id_rs1 = 5'd9;
      #1 chk_out("lu_nonload", 5'b11111, 3'b000, 1'b0);
      step();
      clr_in();
      #1 chk("lu_r0.stall_cnt", 64'(stall_cnt), 64'd1);

      // multiply: 3 stall cycles then release
      ex_mul_start = 1;
      #1 chk_out("mul_c0", 5'b00011, 3'b001, 1'b0);
      step();
      #1 chk_out("mul_c1", 5'b00011, 3'b001, 1'b1);
      step();
      set_lu(5'd3); id_rs1 = 5'd3; id_uses_rs1 = 1;  // ignored while busy
      #1 chk_out("mul_c2", 5'b00011, 3'b001, 1'b1);
      step();
      clr_in(); ex_mul_start = 1;
      #1 chk_out("mul_rel", 5'b11111, 3'b000, 1'b1);
      step();
      ex_mul_start = 0;
      #1 chk_out("mul_done", 5'b11111, 3'b000, 1'b0);
      chk("mul.stall_cnt", 64'(stall_cnt), 64'd4);

      // branch + load-use + mul in same cycle: branch wins
      ex_branch_taken = 1; ex_mul_start = 1;
      set_lu(5'd5); id_rs2 = 5'd5; id_uses_rs2 = 1;
      #1 chk_out("br_lu", 5'b11111, 3'b110, 1'b0);
      step();
      clr_in();
      #1 chk("br.flush_cnt", 64'(flush_cnt), 64'd1);
      chk("br.stall_cnt", 64'(stall_cnt), 64'd4);
      chk_out("br_after", 5'b11111, 3'b000, 1'b0);

      // halt over branch in RUN: no counting
      halt_req = 1; ex_branch_taken = 1;
      #1 chk_out("halt_br", 5'b00000, 3'b000, 1'b0);
      step();
      clr_in();
      #1 chk("halt_br.flush_cnt", 64'(flush_cnt), 64'd1);

      // halt raised during multiply is deferred past release
      ex_mul_start = 1;
      #1 chk_out("mh_c0", 5'b00011, 3'b001, 1'b0);
      step();
      halt_req = 1;
      #1 chk_out("mh_c1", 5'b00011, 3'b001, 1'b1);
      step();
      #1 chk_out("mh_c2", 5'b00011, 3'b001, 1'b1);
      step();
      #1 chk_out("mh_rel", 5'b11111, 3'b000, 1'b1);
      step();
      ex_mul_start = 0;
      #1 chk_out("mh_halt", 5'b00000, 3'b000, 1'b0);
      chk("mh.stall_cnt", 64'(stall_cnt), 64'd7);
      step();
      #1 chk_out("mh_halt2", 5'b00000, 3'b000, 1'b0);
      chk("mh_halt2.stall_cnt", 64'(stall_cnt), 64'd7);
      halt_req = 0;
      #1 chk_out("mh_resume", 5'b11111, 3'b000, 1'b0);
      step();
      chk("mh_resume.stall_cnt", 64'(stall_cnt), 64'd7);

      // async reset mid-multiply (cnt=1)
      ex_mul_start = 1;
      step();
      step();
      #1 chk_out("rm_busy", 5'b00011, 3'b001, 1'b1);
      rst_n = 1'b0;
      #1 chk_out("rm_rst", 5'b00000, 3'b000, 1'b0);
      chk("rm.stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rm.flush_cnt", 64'(flush_cnt), 64'd0);
      #1 rst_n = 1'b1; ex_mul_start = 0;
      step();
      #1 chk_out("rm_run", 5'b11111, 3'b000, 1'b0);
      chk("rm_run.stall_cnt", 64'(stall_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
